// File: rtl/ap_ctrl_txn_tracker_if.sv
// Observed ap_ctrl_hs handshake plus the outgoing transaction-record stream.
// Record stream: a record transfers on a rising edge where rec_valid & rec_ready;
// while rec_valid=1 and rec_ready=0 every rec_* field holds steady.
interface ap_ctrl_txn_tracker_if #(
  parameter int TS_W = 32
);
  logic            mon_ap_start;
  logic            mon_ap_ready;
  logic            mon_ap_done;
  logic            rec_valid;
  logic            rec_ready;
  logic [15:0]     rec_id;
  logic [TS_W-1:0] rec_start_ts;
  logic [TS_W-1:0] rec_done_ts;
  logic [TS_W-1:0] rec_latency;
  logic [TS_W-1:0] rec_interval;

  modport master (
    input  mon_ap_start, mon_ap_ready, mon_ap_done, rec_ready,
    output rec_valid, rec_id, rec_start_ts, rec_done_ts, rec_latency, rec_interval
  );

  modport slave (
    output mon_ap_start, mon_ap_ready, mon_ap_done, rec_ready,
    input  rec_valid, rec_id, rec_start_ts, rec_done_ts, rec_latency, rec_interval
  );
endinterface

// File: rtl/ap_ctrl_txn_tracker.sv
// Passive tracker for one HLS block's ap_ctrl_hs handshake: pairs each accepted
// start with its ap_done and streams out {id, start_ts, done_ts, latency, interval}.
module ap_ctrl_txn_tracker #(
  parameter int TS_W    = 32,
  parameter int PEND_AW = 3,
  parameter int REC_AW  = 2
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 enable,
  input  logic                 finish,
  ap_ctrl_txn_tracker_if.master trk,
  output logic [PEND_AW:0]     outstanding,
  output logic                 err_pend_ovf,
  output logic                 err_orphan_done,
  output logic                 err_rec_ovf,
  output logic [15:0]          drop_cnt,
  output logic                 drained,
  output logic [1:0]           dbg_state
);

  localparam int PCW = PEND_AW + 1;
  localparam int RCW = REC_AW + 1;
  localparam logic [PEND_AW:0] PEND_FULL = PCW'(2 ** PEND_AW);
  localparam logic [REC_AW:0]  REC_FULL  = RCW'(2 ** REC_AW);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  typedef struct packed {
    logic [15:0]     id;
    logic [TS_W-1:0] start_ts;
    logic [TS_W-1:0] interval;
  } pend_t;

  typedef struct packed {
    logic [15:0]     id;
    logic [TS_W-1:0] start_ts;
    logic [TS_W-1:0] done_ts;
    logic [TS_W-1:0] latency;
    logic [TS_W-1:0] interval;
  } rec_t;

  // Assert asynchronously, release synchronously two edges after ap_rst_n rises.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  state_t            state, state_nxt;
  logic [TS_W-1:0]   cyc, last_start;
  logic              have_start;
  logic [15:0]       id_cnt;

  pend_t             pend_mem [2**PEND_AW];
  logic [PEND_AW-1:0] pend_wp, pend_rp;
  logic [PEND_AW:0]  pend_cnt;

  rec_t              rec_mem [2**REC_AW];
  logic [REC_AW-1:0] rec_wp, rec_rp;
  logic [REC_AW:0]   rec_cnt;

  logic accept, done_ev, pend_empty, pend_full, bypass;
  logic pend_push, pend_pop, pend_ovf, orphan;
  logic rec_push, rec_pop, rec_full, rec_wr, rec_drop, rec_valid_i;
  pend_t new_entry, src;
  rec_t  rec_new, rec_head;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (finish) state_nxt = DRAIN;
      DRAIN:   if (rec_cnt == '0) state_nxt = DONE;
      default: state_nxt = DONE;
    endcase
  end

  always_comb begin
    accept     = (state == RUN) & trk.mon_ap_start & trk.mon_ap_ready;
    done_ev    = ((state == RUN) | (state == DRAIN)) & trk.mon_ap_done;
    pend_empty = (pend_cnt == '0);
    pend_full  = (pend_cnt == PEND_FULL);
    // With nothing pending, a same-cycle accept is its own completion.
    bypass     = accept & done_ev & pend_empty;
    pend_pop   = done_ev & ~pend_empty;
    pend_push  = accept & ~bypass & (~pend_full | pend_pop);
    pend_ovf   = accept & pend_full & ~pend_pop;
    orphan     = done_ev & pend_empty & ~accept;

    new_entry          = '0;
    new_entry.id       = id_cnt;
    new_entry.start_ts = cyc;
    new_entry.interval = have_start ? (cyc - last_start) : '0;
    src                = bypass ? new_entry : pend_mem[pend_rp];

    rec_new          = '0;
    rec_new.id       = src.id;
    rec_new.start_ts = src.start_ts;
    rec_new.done_ts  = cyc;
    rec_new.latency  = cyc - src.start_ts;
    rec_new.interval = src.interval;

    rec_valid_i = (rec_cnt != '0);
    rec_head    = rec_mem[rec_rp];
    rec_push    = pend_pop | bypass;
    rec_pop     = rec_valid_i & trk.rec_ready;
    rec_full    = (rec_cnt == REC_FULL);
    rec_wr      = rec_push & (~rec_full | rec_pop);
    rec_drop    = rec_push & rec_full & ~rec_pop;
  end

  always_ff @(posedge ap_clk) begin
    if (pend_push) pend_mem[pend_wp] <= new_entry;
    if (rec_wr)    rec_mem[rec_wp]   <= rec_new;
  end

  always_ff @(posedge ap_clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cyc             <= '0;
      last_start      <= '0;
      have_start      <= 1'b0;
      id_cnt          <= '0;
      pend_wp         <= '0;
      pend_rp         <= '0;
      pend_cnt        <= '0;
      rec_wp          <= '0;
      rec_rp          <= '0;
      rec_cnt         <= '0;
      err_pend_ovf    <= 1'b0;
      err_orphan_done <= 1'b0;
      err_rec_ovf     <= 1'b0;
      drop_cnt        <= '0;
      drained         <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == RUN) || (state == DRAIN)) cyc <= cyc + TS_W'(1);
      // Dropped accepts still consume an id and move the interval reference.
      if (accept) begin
        last_start <= cyc;
        have_start <= 1'b1;
        id_cnt     <= id_cnt + 16'd1;
      end
      if (pend_push) pend_wp <= pend_wp + PEND_AW'(1);
      if (pend_pop)  pend_rp <= pend_rp + PEND_AW'(1);
      pend_cnt <= pend_cnt + PCW'(pend_push) - PCW'(pend_pop);
      if (rec_wr)  rec_wp <= rec_wp + REC_AW'(1);
      if (rec_pop) rec_rp <= rec_rp + REC_AW'(1);
      rec_cnt <= rec_cnt + RCW'(rec_wr) - RCW'(rec_pop);
      if (pend_ovf) err_pend_ovf    <= 1'b1;
      if (orphan)   err_orphan_done <= 1'b1;
      if (rec_drop) begin
        err_rec_ovf <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
      drained <= (state == DONE);
    end
  end

  assign outstanding      = pend_cnt;
  assign dbg_state        = state;
  assign trk.rec_valid    = rec_valid_i;
  assign trk.rec_id       = rec_valid_i ? rec_head.id       : '0;
  assign trk.rec_start_ts = rec_valid_i ? rec_head.start_ts : '0;
  assign trk.rec_done_ts  = rec_valid_i ? rec_head.done_ts  : '0;
  assign trk.rec_latency  = rec_valid_i ? rec_head.latency  : '0;
  assign trk.rec_interval = rec_valid_i ? rec_head.interval : '0;

endmodule

// File: tb/tb_ap_ctrl_txn_tracker.sv
// Bench for ap_ctrl_txn_tracker: narrow timestamps so counter wrap is reachable,
// expected records queued as events are driven and matched on each transfer.
module tb_ap_ctrl_txn_tracker;
  localparam int TS_W    = 8;
  localparam int PEND_AW = 3;
  localparam int REC_AW  = 2;
  localparam int RW      = 16 + 4 * TS_W;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  logic enable = 1'b0;
  logic finish = 1'b0;
  logic [PEND_AW:0] outstanding;
  logic err_pend_ovf, err_orphan_done, err_rec_ovf;
  logic [15:0] drop_cnt;
  logic drained;
  logic [1:0] dbg_state;

  ap_ctrl_txn_tracker_if #(.TS_W(TS_W)) bus ();

  ap_ctrl_txn_tracker #(.TS_W(TS_W), .PEND_AW(PEND_AW), .REC_AW(REC_AW)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .enable(enable), .finish(finish),
    .trk(bus), .outstanding(outstanding), .err_pend_ovf(err_pend_ovf),
    .err_orphan_done(err_orphan_done), .err_rec_ovf(err_rec_ovf),
    .drop_cnt(drop_cnt), .drained(drained), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 ap_clk = ~ap_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  logic [RW-1:0] exp_q[$];
  int vec_cnt = 0;
  int err_cnt = 0;
  int tcyc = 0;
  bit running = 1'b0;

  typedef struct {
    int c; bit acc; bit dn; int exp_out;
    int eid; int es; int elat; int eint;
  } vec_t;
  vec_t tbl[10];

  function automatic logic [RW-1:0] mk_rec(int id, int s, int d, int lat, int iv);
    logic [15:0] i16;
    logic [TS_W-1:0] st, dn, lt, ivl;
    i16 = 16'(id); st = TS_W'(s); dn = TS_W'(d); lt = TS_W'(lat); ivl = TS_W'(iv);
    return {i16, st, dn, lt, ivl};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Transfers are judged just before the edge that performs them.
  task automatic tick();
    logic [RW-1:0] got, e;
    if (bus.rec_valid && bus.rec_ready) begin
      got = {bus.rec_id, bus.rec_start_ts, bus.rec_done_ts, bus.rec_latency, bus.rec_interval};
      if (exp_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL unexpected_record: got 0x%0h expected no record", got);
      end else begin
        e = exp_q.pop_front();
        check("record", 64'(got), 64'(e));
      end
    end
    @(posedge ap_clk);
    if (running) tcyc = (tcyc + 1) % (1 << TS_W);
    #1;
  endtask

  // Driver tasks
  task automatic run_to(int c);
    int n;
    n = 0;
    while (tcyc != c && n < 400) begin
      tick();
      n++;
    end
    if (tcyc != c) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL run_to_timeout: got cyc %0d expected %0d", tcyc, c);
    end
  endtask

  task automatic ev(bit s, bit r, bit d);
    bus.mon_ap_start = s;
    bus.mon_ap_ready = r;
    bus.mon_ap_done  = d;
    tick();
    bus.mon_ap_start = 1'b0;
    bus.mon_ap_ready = 1'b0;
    bus.mon_ap_done  = 1'b0;
  endtask

  task automatic check_idle_outputs(string tag);
    check({tag, "_outstanding"}, 64'(outstanding), 0);
    check({tag, "_rec_valid"}, 64'(bus.rec_valid), 0);
    check({tag, "_rec_id"}, 64'(bus.rec_id), 0);
    check({tag, "_flags"}, 64'({err_pend_ovf, err_orphan_done, err_rec_ovf}), 0);
    check({tag, "_drop_cnt"}, 64'(drop_cnt), 0);
    check({tag, "_drained"}, 64'(drained), 0);
    check({tag, "_state"}, 64'(dbg_state), 0);
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    enable = 1'b0;
    finish = 1'b0;
    bus.mon_ap_start = 1'b0;
    bus.mon_ap_ready = 1'b0;
    bus.mon_ap_done  = 1'b0;
    running = 1'b0;
    tcyc = 0;
    exp_q.delete();
    #1;
    tick();
    tick();
    check_idle_outputs("reset");
    ap_rst_n = 1'b1;
    tick();
    tick();
    enable = 1'b1;
    tick();
    enable = 1'b0;
    running = 1'b1;
    tcyc = 0;
  endtask

  initial begin
    bus.mon_ap_start = 1'b0;
    bus.mon_ap_ready = 1'b0;
    bus.mon_ap_done  = 1'b0;
    bus.rec_ready    = 1'b1;

    tbl[0] = '{10, 1'b1, 1'b0, 1, 0, 0, 0, 0};
    tbl[1] = '{14, 1'b1, 1'b0, 2, 0, 0, 0, 0};
    tbl[2] = '{18, 1'b1, 1'b0, 3, 0, 0, 0, 0};
    tbl[3] = '{20, 1'b0, 1'b1, 2, 0, 10, 10, 0};
    tbl[4] = '{24, 1'b0, 1'b1, 1, 1, 14, 10, 4};
    tbl[5] = '{28, 1'b0, 1'b1, 0, 2, 18, 10, 4};
    tbl[6] = '{30, 1'b1, 1'b1, 0, 3, 30, 0, 12};
    tbl[7] = '{33, 1'b1, 1'b0, 1, 0, 0, 0, 0};
    tbl[8] = '{36, 1'b1, 1'b1, 1, 4, 33, 3, 3};
    tbl[9] = '{40, 1'b0, 1'b1, 0, 5, 36, 4, 3};

    // Single transaction
    do_reset();
    bus.rec_ready = 1'b1;
    check("run_state", 64'(dbg_state), 1);
    run_to(3);
    ev(1'b1, 1'b0, 1'b0);
    check("start_without_ready", 64'(outstanding), 0);
    run_to(5);
    ev(1'b1, 1'b1, 1'b0);
    check("single_outstanding", 64'(outstanding), 1);
    run_to(17);
    exp_q.push_back(mk_rec(0, 5, 17, 12, 0));
    ev(1'b0, 1'b0, 1'b1);
    check("single_valid_next", 64'(bus.rec_valid), 1);
    check("single_pend_empty", 64'(outstanding), 0);
    tick();
    check("single_valid_one_cycle", 64'(bus.rec_valid), 0);
    check("single_q_empty", 64'(exp_q.size()), 0);

    // Pipelined overlap and simultaneous events, table-driven
    do_reset();
    bus.rec_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run_to(tbl[i].c);
      if (tbl[i].dn)
        exp_q.push_back(mk_rec(tbl[i].eid, tbl[i].es, tbl[i].c, tbl[i].elat, tbl[i].eint));
      ev(tbl[i].acc, tbl[i].acc, tbl[i].dn);
      check($sformatf("tbl%0d_outstanding", i), 64'(outstanding), 64'(tbl[i].exp_out));
    end
    tick();
    tick();
    check("tbl_q_empty", 64'(exp_q.size()), 0);
    check("tbl_no_flags", 64'({err_pend_ovf, err_orphan_done, err_rec_ovf}), 0);

    // Pending and record overflow
    do_reset();
    bus.rec_ready = 1'b0;
    run_to(1);
    for (int i = 0; i < 9; i++) ev(1'b1, 1'b1, 1'b0);
    check("ovf_outstanding", 64'(outstanding), 8);
    check("ovf_pend_flag", 64'(err_pend_ovf), 1);
    check("ovf_rec_flag_clear", 64'(err_rec_ovf), 0);
    run_to(12);
    for (int i = 0; i < 8; i++) begin
      if (i < 4) exp_q.push_back(mk_rec(i, 1 + i, 12 + i, 11, (i == 0) ? 0 : 1));
      ev(1'b0, 1'b0, 1'b1);
    end
    check("ovf_drain_pend", 64'(outstanding), 0);
    check("ovf_drop_cnt", 64'(drop_cnt), 4);
    check("ovf_rec_flag", 64'(err_rec_ovf), 1);
    check("ovf_rec_valid", 64'(bus.rec_valid), 1);
    tick();
    tick();
    check("stall_id_stable", 64'(bus.rec_id), 0);
    check("stall_start_stable", 64'(bus.rec_start_ts), 1);
    check("no_orphan_yet", 64'(err_orphan_done), 0);
    ev(1'b0, 1'b0, 1'b1);
    check("orphan_flag", 64'(err_orphan_done), 1);
    bus.rec_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("b2b_q_empty", 64'(exp_q.size()), 0);
    check("b2b_valid_low", 64'(bus.rec_valid), 0);
    tick();

    // Counter wrap, then drain
    do_reset();
    bus.rec_ready = 1'b1;
    run_to(254);
    ev(1'b1, 1'b1, 1'b0);
    run_to(3);
    exp_q.push_back(mk_rec(0, 254, 3, 5, 0));
    ev(1'b0, 1'b0, 1'b1);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    check("drain_state", 64'(dbg_state), 2);
    ev(1'b1, 1'b1, 1'b0);
    check("drain_accept_ignored", 64'(outstanding), 0);
    check("drain_no_ovf", 64'(err_pend_ovf), 0);
    check("done_state", 64'(dbg_state), 3);
    check("drained_lag", 64'(drained), 0);
    tick();
    check("drained_high", 64'(drained), 1);
    ev(1'b1, 1'b1, 1'b0);
    ev(1'b0, 1'b0, 1'b1);
    tick();
    check("done_no_record", 64'(bus.rec_valid), 0);
    check("done_no_orphan", 64'(err_orphan_done), 0);
    check("wrap_q_empty", 64'(exp_q.size()), 0);

    // Reset in the middle of traffic
    do_reset();
    bus.rec_ready = 1'b0;
    run_to(2);
    for (int i = 0; i < 5; i++) ev(1'b1, 1'b1, 1'b0);
    run_to(8);
    ev(1'b0, 1'b0, 1'b1);
    ev(1'b0, 1'b0, 1'b1);
    check("midrst_pending", 64'(outstanding), 3);
    check("midrst_buffered", 64'(bus.rec_valid), 1);
    ap_rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    do_reset();
    bus.rec_ready = 1'b1;
    run_to(1);
    ev(1'b1, 1'b1, 1'b0);
    run_to(3);
    exp_q.push_back(mk_rec(0, 1, 3, 2, 0));
    ev(1'b0, 1'b0, 1'b1);
    tick();
    tick();
    check("midrst_id_restart", 64'(exp_q.size()), 0);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
